// File: rtl/otter_hazard_ctrl_if.sv
// Signal bundle between the OTTER pipeline datapath and its hazard controller.
// The datapath is the master: it supplies register/stage info and consumes stalls, valids and selects.
interface otter_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       de_rs1;
   logic [4:0]       de_rs2;
   logic             de_rs1_used;
   logic             de_rs2_used;
   logic [4:0]       ex_rd;
   logic             ex_reg_write;
   logic             ex_mem_read;
   logic [4:0]       mem_rd;
   logic             mem_reg_write;
   logic             branch_taken;
   logic             imem_wait;
   logic             dmem_wait;

   logic             stall_pc;
   logic             stall_if;
   logic             stall_de;
   logic             stall_ex;
   logic             stall_mem;
   logic             stall_wb;
   logic             if_de_valid;
   logic             de_ex_valid;
   logic             ex_mem_valid;
   logic             mem_wb_valid;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             load_use;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output de_rs1, de_rs2, de_rs1_used, de_rs2_used,
      output ex_rd, ex_reg_write, ex_mem_read,
      output mem_rd, mem_reg_write,
      output branch_taken, imem_wait, dmem_wait,
      input  stall_pc, stall_if, stall_de, stall_ex, stall_mem, stall_wb,
      input  if_de_valid, de_ex_valid, ex_mem_valid, mem_wb_valid,
      input  fwd_a_sel, fwd_b_sel, load_use, stall_cnt, flush_cnt
   );

   modport slave (
      input  de_rs1, de_rs2, de_rs1_used, de_rs2_used,
      input  ex_rd, ex_reg_write, ex_mem_read,
      input  mem_rd, mem_reg_write,
      input  branch_taken, imem_wait, dmem_wait,
      output stall_pc, stall_if, stall_de, stall_ex, stall_mem, stall_wb,
      output if_de_valid, de_ex_valid, ex_mem_valid, mem_wb_valid,
      output fwd_a_sel, fwd_b_sel, load_use, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage OTTER pipeline.
// Priority each cycle: dmem_wait > taken branch > load-use > imem_wait > normal advance.
module otter_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic               CLK,
   input  logic               RESET,
   otter_hazard_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      ACT_NORMAL,
      ACT_IMEM,
      ACT_LOAD_USE,
      ACT_BRANCH,
      ACT_DMEM
   } act_t;

   logic             r_if_de_valid;
   logic             r_de_ex_valid;
   logic             r_ex_mem_valid;
   logic             r_mem_wb_valid;
   logic [1:0]       r_fwd_a_sel;
   logic [1:0]       r_fwd_b_sel;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [1:0][4:0]  w_src;
   logic [1:0]       w_used;
   logic [1:0]       w_match;
   logic [1:0]       w_ex_hit;
   logic [1:0]       w_mem_hit;
   logic [1:0][1:0]  w_fwd_next;
   logic             w_br;
   logic             w_load_use;
   act_t             w_act;

   assign w_src[0]  = bus.de_rs1;
   assign w_src[1]  = bus.de_rs2;
   assign w_used[0] = bus.de_rs1_used;
   assign w_used[1] = bus.de_rs2_used;

   // Per-operand dependence; the EX producer is nearer and therefore wins over MEM.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         assign w_match[gi]    = w_used[gi] && (w_src[gi] != 5'd0);
         assign w_ex_hit[gi]   = w_match[gi] && (w_src[gi] == bus.ex_rd);
         assign w_mem_hit[gi]  = w_match[gi] && (w_src[gi] == bus.mem_rd);
         assign w_fwd_next[gi] =
            (r_de_ex_valid && bus.ex_reg_write && (bus.ex_rd != 5'd0) && w_ex_hit[gi]) ? 2'd1 :
            (r_ex_mem_valid && bus.mem_reg_write && (bus.mem_rd != 5'd0) && w_mem_hit[gi]) ? 2'd2 :
            2'd0;
      end
   endgenerate

   assign w_br       = bus.branch_taken && r_de_ex_valid;
   assign w_load_use = r_if_de_valid && r_de_ex_valid && bus.ex_mem_read &&
                       (bus.ex_rd != 5'd0) && (|w_ex_hit);

   always_comb begin
      w_act = ACT_NORMAL;
      if (bus.dmem_wait)      w_act = ACT_DMEM;
      else if (w_br)          w_act = ACT_BRANCH;
      else if (w_load_use)    w_act = ACT_LOAD_USE;
      else if (bus.imem_wait) w_act = ACT_IMEM;
   end

   always_comb begin
      bus.stall_pc  = 1'b0;
      bus.stall_if  = 1'b0;
      bus.stall_de  = 1'b0;
      bus.stall_ex  = 1'b0;
      bus.stall_mem = 1'b0;
      bus.stall_wb  = 1'b0;
      if (!RESET) begin
         case (w_act)
            ACT_DMEM: begin
               bus.stall_pc  = 1'b1;
               bus.stall_if  = 1'b1;
               bus.stall_de  = 1'b1;
               bus.stall_ex  = 1'b1;
               bus.stall_mem = 1'b1;
               bus.stall_wb  = 1'b1;
            end
            ACT_LOAD_USE: begin
               bus.stall_pc = 1'b1;
               bus.stall_if = 1'b1;
               bus.stall_de = 1'b1;
            end
            ACT_IMEM: begin
               bus.stall_pc = 1'b1;
               bus.stall_if = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_if_de_valid  <= 1'b0;
         r_de_ex_valid  <= 1'b0;
         r_ex_mem_valid <= 1'b0;
         r_mem_wb_valid <= 1'b0;
         r_fwd_a_sel    <= 2'd0;
         r_fwd_b_sel    <= 2'd0;
         r_stall_cnt    <= '0;
         r_flush_cnt    <= '0;
      end else begin
         case (w_act)
            ACT_DMEM: begin
               if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            ACT_BRANCH: begin
               // The branch itself keeps going into MEM; the two younger slots are squashed.
               r_if_de_valid  <= 1'b0;
               r_de_ex_valid  <= 1'b0;
               r_ex_mem_valid <= 1'b1;
               r_mem_wb_valid <= r_ex_mem_valid;
               r_fwd_a_sel    <= 2'd0;
               r_fwd_b_sel    <= 2'd0;
               if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            ACT_LOAD_USE: begin
               r_de_ex_valid  <= 1'b0;
               r_ex_mem_valid <= r_de_ex_valid;
               r_mem_wb_valid <= r_ex_mem_valid;
               r_fwd_a_sel    <= 2'd0;
               r_fwd_b_sel    <= 2'd0;
               if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            ACT_IMEM: begin
               r_if_de_valid  <= 1'b0;
               r_de_ex_valid  <= r_if_de_valid;
               r_ex_mem_valid <= r_de_ex_valid;
               r_mem_wb_valid <= r_ex_mem_valid;
               r_fwd_a_sel    <= w_fwd_next[0];
               r_fwd_b_sel    <= w_fwd_next[1];
            end
            default: begin
               r_if_de_valid  <= 1'b1;
               r_de_ex_valid  <= r_if_de_valid;
               r_ex_mem_valid <= r_de_ex_valid;
               r_mem_wb_valid <= r_ex_mem_valid;
               r_fwd_a_sel    <= w_fwd_next[0];
               r_fwd_b_sel    <= w_fwd_next[1];
            end
         endcase
      end
   end

   assign bus.if_de_valid  = r_if_de_valid;
   assign bus.de_ex_valid  = r_de_ex_valid;
   assign bus.ex_mem_valid = r_ex_mem_valid;
   assign bus.mem_wb_valid = r_mem_wb_valid;
   assign bus.fwd_a_sel    = r_fwd_a_sel;
   assign bus.fwd_b_sel    = r_fwd_b_sel;
   assign bus.load_use     = w_load_use;
   assign bus.stall_cnt    = r_stall_cnt;
   assign bus.flush_cnt    = r_flush_cnt;
endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Bench for otter_hazard_ctrl: per-cycle reference model feeding an expected-state queue,
// plus directed checks of the pipeline hazard scenarios.
module tb_otter_hazard_ctrl;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   otter_hazard_ctrl_if #(.CNT_W(CW)) hz();
   otter_hazard_ctrl #(.CNT_W(CW)) dut (.CLK(clk), .RESET(rst), .bus(hz));

   typedef struct packed {
      logic          ifd;
      logic          dex;
      logic          exm;
      logic          mwb;
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } regs_t;

   regs_t m = '0;
   regs_t exp_q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    n_txn = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic regs_t observe();
      regs_t r;
      r.ifd = hz.if_de_valid;
      r.dex = hz.de_ex_valid;
      r.exm = hz.ex_mem_valid;
      r.mwb = hz.mem_wb_valid;
      r.fa  = hz.fwd_a_sel;
      r.fb  = hz.fwd_b_sel;
      r.sc  = hz.stall_cnt;
      r.fc  = hz.flush_cnt;
      return r;
   endfunction

   task automatic clr();
      hz.de_rs1 = 0; hz.de_rs2 = 0; hz.de_rs1_used = 0; hz.de_rs2_used = 0;
      hz.ex_rd = 0; hz.ex_reg_write = 0; hz.ex_mem_read = 0;
      hz.mem_rd = 0; hz.mem_reg_write = 0;
      hz.branch_taken = 0; hz.imem_wait = 0; hz.dmem_wait = 0;
   endtask

   // One clock: check combinational outputs against the model, queue next state, compare after the edge.
   task automatic cycle(input string tag);
      logic       m1, m2, lu, br;
      logic [1:0] fa, fb;
      logic [6:0] exp_c, obs_c;
      regs_t      nx, got, want;
      @(negedge clk);
      m1 = hz.de_rs1_used && (hz.de_rs1 != 0);
      m2 = hz.de_rs2_used && (hz.de_rs2 != 0);
      lu = m.ifd && m.dex && hz.ex_mem_read && (hz.ex_rd != 0) &&
           ((m1 && hz.de_rs1 == hz.ex_rd) || (m2 && hz.de_rs2 == hz.ex_rd));
      br = hz.branch_taken && m.dex;
      fa = 2'd0;
      if (m.dex && hz.ex_reg_write && hz.ex_rd != 0 && m1 && hz.de_rs1 == hz.ex_rd) fa = 2'd1;
      else if (m.exm && hz.mem_reg_write && hz.mem_rd != 0 && m1 && hz.de_rs1 == hz.mem_rd) fa = 2'd2;
      fb = 2'd0;
      if (m.dex && hz.ex_reg_write && hz.ex_rd != 0 && m2 && hz.de_rs2 == hz.ex_rd) fb = 2'd1;
      else if (m.exm && hz.mem_reg_write && hz.mem_rd != 0 && m2 && hz.de_rs2 == hz.mem_rd) fb = 2'd2;
      nx = m;
      if (rst) begin
         exp_c = {6'b000000, lu};
         nx = '0;
      end else if (hz.dmem_wait) begin
         exp_c = {6'b111111, lu};
         nx.sc = sat(m.sc);
      end else if (br) begin
         exp_c = {6'b000000, lu};
         nx.ifd = 0; nx.dex = 0; nx.exm = 1; nx.mwb = m.exm;
         nx.fa = 0; nx.fb = 0; nx.fc = sat(m.fc);
      end else if (lu) begin
         exp_c = {6'b111000, 1'b1};
         nx.dex = 0; nx.exm = m.dex; nx.mwb = m.exm;
         nx.fa = 0; nx.fb = 0; nx.sc = sat(m.sc);
      end else if (hz.imem_wait) begin
         exp_c = {6'b110000, 1'b0};
         nx.ifd = 0; nx.dex = m.ifd; nx.exm = m.dex; nx.mwb = m.exm;
         nx.fa = fa; nx.fb = fb;
      end else begin
         exp_c = {6'b000000, 1'b0};
         nx.ifd = 1; nx.dex = m.ifd; nx.exm = m.dex; nx.mwb = m.exm;
         nx.fa = fa; nx.fb = fb;
      end
      obs_c = {hz.stall_pc, hz.stall_if, hz.stall_de, hz.stall_ex, hz.stall_mem, hz.stall_wb, hz.load_use};
      check($sformatf("%s/comb", tag), 64'(obs_c), 64'(exp_c));
      exp_q.push_back(nx);
      @(posedge clk);
      #1;
      got = observe();
      if (exp_q.size() == 0) begin
         check($sformatf("%s/queue", tag), 64'd0, 64'd1);
      end else begin
         want = exp_q.pop_front();
         check($sformatf("%s/regs", tag), 64'(got), 64'(want));
         m = want;
      end
      n_txn++;
      $display("txn %0d %s stalls=%b valids=%b%b%b%b fa=%0d fb=%0d sc=%0d fc=%0d", n_txn, tag,
               obs_c[6:1], got.ifd, got.dex, got.exm, got.mwb, got.fa, got.fb, got.sc, got.fc);
   endtask

   initial begin
      clr();
      rst = 1'b1;
      cycle("rst0");
      cycle("rst1");
      check("rst_valids", {hz.if_de_valid, hz.de_ex_valid, hz.ex_mem_valid, hz.mem_wb_valid}, 0);
      check("rst_cnts", {hz.stall_cnt, hz.flush_cnt}, 0);

      rst = 1'b0;
      cycle("fill1");
      check("fill_ifde", hz.if_de_valid, 1);
      check("fill_mwb_early", hz.mem_wb_valid, 0);
      cycle("fill2");
      cycle("fill3");
      cycle("fill4");
      check("fill_mwb", hz.mem_wb_valid, 1);

      // Load-use: EX = LOAD x5, DE reads x5.
      hz.ex_rd = 5; hz.ex_mem_read = 1; hz.ex_reg_write = 1;
      hz.de_rs1 = 5; hz.de_rs1_used = 1;
      #1;
      check("lu_flag", hz.load_use, 1);
      check("lu_stalls", {hz.stall_pc, hz.stall_if, hz.stall_de, hz.stall_ex}, 4'b1110);
      cycle("loaduse");
      check("lu_bubble", hz.de_ex_valid, 0);
      check("lu_stall_cnt", hz.stall_cnt, 1);
      hz.ex_rd = 0; hz.ex_mem_read = 0; hz.ex_reg_write = 0;
      hz.mem_rd = 5; hz.mem_reg_write = 1;
      #1;
      check("lu_released", hz.stall_pc, 0);
      cycle("lu_fwd");
      check("lu_fwd_a", hz.fwd_a_sel, 2);

      // EX and MEM both write x7: nearest producer wins.
      clr();
      hz.ex_rd = 7; hz.ex_reg_write = 1;
      hz.mem_rd = 7; hz.mem_reg_write = 1;
      hz.de_rs2 = 7; hz.de_rs2_used = 1;
      cycle("fwd_prio");
      check("fwd_b_ex", hz.fwd_b_sel, 1);
      hz.ex_rd = 0; hz.mem_rd = 0; hz.ex_mem_read = 1;
      #1;
      check("rd0_no_lu", hz.load_use, 0);
      cycle("fwd_rd0");
      check("fwd_b_rd0", hz.fwd_b_sel, 0);

      // Branch together with load-use.
      clr();
      hz.ex_rd = 5; hz.ex_mem_read = 1; hz.de_rs1 = 5; hz.de_rs1_used = 1;
      hz.branch_taken = 1;
      #1;
      check("br_lu_flag", hz.load_use, 1);
      check("br_stalls", {hz.stall_pc, hz.stall_if, hz.stall_de, hz.stall_ex, hz.stall_mem, hz.stall_wb}, 0);
      cycle("br_vs_lu");
      check("br_squash", {hz.if_de_valid, hz.de_ex_valid}, 0);
      check("br_flush_cnt", hz.flush_cnt, 1);
      check("br_stall_cnt", hz.stall_cnt, 1);

      clr();
      cycle("refill1");
      cycle("refill2");

      // dmem_wait masks a pending branch for three cycles.
      hz.dmem_wait = 1; hz.branch_taken = 1;
      #1;
      check("dmem_stalls", {hz.stall_pc, hz.stall_if, hz.stall_de, hz.stall_ex, hz.stall_mem, hz.stall_wb}, 6'h3f);
      for (int i = 0; i < 3; i++) cycle("dmem");
      check("dmem_frozen", {hz.if_de_valid, hz.de_ex_valid, hz.ex_mem_valid, hz.mem_wb_valid}, 4'b1100);
      check("dmem_stall_cnt", hz.stall_cnt, 4);
      check("dmem_flush_cnt", hz.flush_cnt, 1);
      hz.dmem_wait = 0;
      cycle("dmem_br");
      check("late_flush_cnt", hz.flush_cnt, 2);
      check("late_squash", {hz.if_de_valid, hz.de_ex_valid}, 0);

      // Random traffic including occasional mid-operation reset.
      for (int i = 0; i < 300; i++) begin
         hz.de_rs1 = 5'($urandom_range(0, 3)); hz.de_rs2 = 5'($urandom_range(0, 3));
         hz.de_rs1_used = 1'($urandom); hz.de_rs2_used = 1'($urandom);
         hz.ex_rd = 5'($urandom_range(0, 3)); hz.ex_reg_write = 1'($urandom);
         hz.ex_mem_read = ($urandom_range(0, 2) == 0);
         hz.mem_rd = 5'($urandom_range(0, 3)); hz.mem_reg_write = 1'($urandom);
         hz.branch_taken = ($urandom_range(0, 4) == 0);
         hz.imem_wait = ($urandom_range(0, 5) == 0);
         hz.dmem_wait = ($urandom_range(0, 6) == 0);
         rst = ($urandom_range(0, 49) == 0);
         cycle("rand");
      end

      // Saturation of the 4-bit stall counter.
      clr();
      rst = 1'b1;
      cycle("sat_rst");
      rst = 1'b0;
      hz.dmem_wait = 1;
      for (int i = 0; i < 20; i++) cycle("sat");
      check("sat_stall_cnt", hz.stall_cnt, 15);
      check("sat_flush_cnt", hz.flush_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/otter_hazard_ctrl.md
Name: otter_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipelined OTTER (IF, DE, EX, MEM, WB).
- Owns the four inter-stage valid bits and drives the per-stage stall enables.
- Registers the EX-operand forwarding selects as each instruction leaves DE.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
de_rs1, de_rs2  in  5 each  source register addresses of the instruction in DE (ir[19:15], ir[24:20])
de_rs1_used, de_rs2_used  in  1 each  DE instruction actually reads rs1 / rs2
ex_rd  in  5  destination register of the instruction in EX
ex_reg_write, ex_mem_read  in  1 each  EX instruction writes the reg file / is a LOAD
mem_rd  in  5  destination register of the instruction in MEM
mem_reg_write  in  1  MEM instruction writes the reg file
branch_taken  in  1  EX redirect request (pcSel != 0); qualified internally by de_ex_valid
imem_wait  in  1  instruction memory cannot deliver this cycle
dmem_wait  in  1  data memory busy; whole pipeline must freeze
stall_pc, stall_if, stall_de, stall_ex, stall_mem, stall_wb  out  1 each  hold enables for PC and pipeline registers
if_de_valid, de_ex_valid, ex_mem_valid, mem_wb_valid  out  1 each  stage-register valid bits (registered)
fwd_a_sel, fwd_b_sel  out  2 each  registered EX operand select: 0 = reg file, 1 = EX/MEM ALU result, 2 = WB write data
load_use  out  1  combinational load-use hazard indicator
stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
Reset
- RESET synchronous, active-high, highest priority.
- All valids, fwd_*_sel, stall_cnt and flush_cnt go to 0.
- Stall outputs are combinational. With RESET high they are all 0.

Qualified terms
- br = branch_taken && de_ex_valid.
- match1 = de_rs1_used && de_rs1 != 0. match2 is the same for rs2.
- load_use = if_de_valid && de_ex_valid && ex_mem_read && ex_rd != 0 && ((match1 && de_rs1 == ex_rd) || (match2 && de_rs2 == ex_rd)).

Per-cycle priority: dmem_wait > br > load_use > imem_wait > normal
- dmem_wait: all six stall outputs = 1. Valids, fwd selects and flush_cnt hold. stall_cnt += 1. A simultaneous br is ignored; it re-presents once EX unfreezes.
- br: all stalls = 0, so PC loads the target.
  - if_de_valid <= 0 and de_ex_valid <= 0.
  - ex_mem_valid <= 1, because the branch itself proceeds.
  - mem_wb_valid <= ex_mem_valid.
  - fwd selects <= 0. flush_cnt += 1.
  - br beats a simultaneous load_use and imem_wait.
- load_use: stall_pc = stall_if = stall_de = 1; all other stalls = 0.
  - if_de_valid holds. de_ex_valid <= 0, inserting a bubble.
  - ex_mem_valid <= de_ex_valid. mem_wb_valid <= ex_mem_valid.
  - fwd selects <= 0. stall_cnt += 1.
- imem_wait: stall_pc = stall_if = 1.
  - if_de_valid <= 0.
  - de_ex_valid <= if_de_valid. Later stages advance normally.
  - fwd selects are computed as in normal.
- normal: all stalls = 0.
  - if_de_valid <= 1, de_ex_valid <= if_de_valid, ex_mem_valid <= de_ex_valid, mem_wb_valid <= ex_mem_valid.

Forwarding selects (fwd_a_sel shown; fwd_b_sel is identical with rs2)
- Loaded only in the normal and imem_wait cases.
- Value 1 if de_ex_valid && ex_reg_write && ex_rd != 0 && match1 && de_rs1 == ex_rd.
- Otherwise value 2 if ex_mem_valid && mem_reg_write && mem_rd != 0 && match1 && de_rs1 == mem_rd.
- Otherwise value 0. The nearest producer wins.
- Consequence: after a load-use bubble the load has moved to MEM, so the dependent instruction receives select 2.
- The register file is write-before-read. This block does no WB-to-DE bypass.

Counters
- Saturate at all-ones; no wrap.

Reset mid-operation
- Squashes all in-flight instructions immediately; no counter update that cycle.

Test Plan:
- Reset hold: RESET high for 2 cycles, then low with no waits -> all valids and counters 0 during reset; valid bits fill on successive cycles (if_de_valid after 1 cycle, mem_wb_valid after 4).
- Load-use: EX = LOAD x5, DE = ADD reading rs1 = 5 -> load_use = 1 and stall_pc/if/de = 1 for exactly 1 cycle; de_ex_valid = 0 next cycle; ADD then enters EX with fwd_a_sel = 2; stall_cnt = 1.
- Forward priority: EX writes x7, MEM writes x7, DE reads rs2 = 7 -> fwd_b_sel = 1. Repeat with rd = 0 -> fwd_b_sel = 0 and no load_use.
- Branch flush beats load-use: br and load_use in the same cycle -> all stalls 0; if_de_valid = de_ex_valid = 0 next cycle; flush_cnt = 1; stall_cnt unchanged.
- dmem_wait for 3 cycles with branch_taken high -> all stalls 1, valids frozen, stall_cnt += 3, flush_cnt unchanged; flush occurs on the first cycle after dmem_wait drops.
- Saturation with CNT_W = 4: 20 consecutive dmem_wait cycles -> stall_cnt sticks at 15.
